ext_share_arbiter: RTL and testbench

- Shares one sign/zero-extension datapath between two requesters: requester 0 is the ID-stage immediate path and requester 1 is the MEM-stage load byte/halfword path.
- Arbitrates round-robin, applies the requested extension mode, and registers the result in a one-entry output buffer with a valid/ready handshake.
- Sits between the decode/load-align logic and the ALU-operand / write-back muxes.

---
 rtl/ext_share_arbiter_if.sv | 32 +++
 rtl/ext_share_arbiter.sv | 99 +++++++++
 tb/tb_ext_share_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_share_arbiter_if.sv
// Handshake bundle between the two extension requesters,
// the shared extender and its result consumer.
interface ext_share_arbiter_if;
  logic        Req0Valid;
  logic [15:0] Req0Data;
  logic [1:0]  Req0Mode;
  logic        Req0Ready;
  logic        Req1Valid;
  logic [15:0] Req1Data;
  logic [1:0]  Req1Mode;
  logic        Req1Ready;
  logic        OutValid;
  logic [31:0] OutData;
  logic        OutId;
  logic        OutReady;

  modport slave (
    input  Req0Valid, Req0Data, Req0Mode,
    input  Req1Valid, Req1Data, Req1Mode,
    input  OutReady,
    output Req0Ready, Req1Ready,
    output OutValid, OutData, OutId
  );

  modport master (
    output Req0Valid, Req0Data, Req0Mode,
    output Req1Valid, Req1Data, Req1Mode,
    output OutReady,
    input  Req0Ready, Req1Ready,
    input  OutValid, OutData, OutId
  );
endinterface

// File: rtl/ext_share_arbiter.sv
// Round-robin shared sign/zero extender for the ID immediate
// path (req 0) and the MEM load-align path (req 1).
module ext_share_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  ext_share_arbiter_if.slave bus,
  output logic [CNT_W-1:0] Grant0Cnt,
  output logic [CNT_W-1:0] Grant1Cnt
);

  function automatic logic [31:0] ext_f(
    input logic [15:0] d,
    input logic [1:0]  m
  );
    logic [31:0] r;
    r = '0;
    unique case (m)
      2'b00:   r = {{16{d[15]}}, d};
      2'b01:   r = {16'h0000, d};
      2'b10:   r = {{24{d[7]}}, d[7:0]};
      default: r = {d, 16'h0000};
    endcase
    return r;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_id_q, out_id_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic        space;
  logic        gnt0, gnt1;
  logic        xfer0, xfer1;
  logic [15:0] sel_data;
  logic [1:0]  sel_mode;

  // ptr_q names the requester that wins when both are valid
  always_comb begin
    space = !out_valid_q | bus.OutReady;
    gnt0  = bus.Req0Valid & (!bus.Req1Valid | !ptr_q);
    gnt1  = bus.Req1Valid & (!bus.Req0Valid | ptr_q);
    xfer0 = gnt0 & space;
    xfer1 = gnt1 & space;
    sel_data = xfer1 ? bus.Req1Data : bus.Req0Data;
    sel_mode = xfer1 ? bus.Req1Mode : bus.Req0Mode;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    if (xfer0 | xfer1) begin
      out_valid_d = 1'b1;
      out_data_d  = ext_f(sel_data, sel_mode);
      out_id_d    = xfer1;
      ptr_d       = !xfer1;
    end else if (bus.OutReady) begin
      out_valid_d = 1'b0;
    end
    if (xfer0 && (cnt0_q != '1))
      cnt0_d = cnt0_q + CNT_W'(1);
    if (xfer1 && (cnt1_q != '1))
      cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= 1'b0;
      ptr_q       <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign bus.Req0Ready = xfer0;
  assign bus.Req1Ready = xfer1;
  assign bus.OutValid  = out_valid_q;
  assign bus.OutData   = out_data_q;
  assign bus.OutId     = out_id_q;
  assign Grant0Cnt     = cnt0_q;
  assign Grant1Cnt     = cnt1_q;

endmodule

// File: tb/tb_ext_share_arbiter.sv
// Scoreboard bench for ext_share_arbiter: directed scenarios
// followed by randomized traffic against a reference model.
module tb_ext_share_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] g0, g1;
  logic [1:0] s0, s1;

  ext_share_arbiter_if bus();
  ext_share_arbiter_if bus2();

  assign bus2.Req0Valid = bus.Req0Valid;
  assign bus2.Req0Data  = bus.Req0Data;
  assign bus2.Req0Mode  = bus.Req0Mode;
  assign bus2.Req1Valid = bus.Req1Valid;
  assign bus2.Req1Data  = bus.Req1Data;
  assign bus2.Req1Mode  = bus.Req1Mode;
  assign bus2.OutReady  = bus.OutReady;

  ext_share_arbiter #(.CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus.slave),
    .Grant0Cnt(g0), .Grant1Cnt(g1)
  );

  ext_share_arbiter #(.CNT_W(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .bus(bus2.slave),
    .Grant0Cnt(s0), .Grant1Cnt(s1)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] data;
    logic        id;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  int   prio_m;
  bit   busy_m;
  int   c0, c1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic int sat(int c, int m);
    return (c > m) ? m : c;
  endfunction

  function automatic logic [31:0] ext_m(logic [15:0] d, logic [1:0] m);
    logic [7:0] b;
    b = d[7:0];
    case (m)
      2'd0:    return 32'($signed(d));
      2'd1:    return 32'(d);
      2'd2:    return 32'($signed(b));
      default: return 32'(d) << 16;
    endcase
  endfunction

  task automatic model_reset();
    prio_m = 0;
    busy_m = 0;
    c0 = 0;
    c1 = 0;
    q.delete();
  endtask

  task automatic cycle(
    input bit v0, input logic [15:0] d0, input logic [1:0] m0,
    input bit v1, input logic [15:0] d1, input logic [1:0] m1,
    input bit ordy, output bit a0, output bit a1
  );
    int  g;
    bit  room;
    @(negedge Clk);
    bus.Req0Valid = v0; bus.Req0Data = d0; bus.Req0Mode = m0;
    bus.Req1Valid = v1; bus.Req1Data = d1; bus.Req1Mode = m1;
    bus.OutReady  = ordy;
    #1;
    chk("gcnt0", g0, sat(c0, 255));
    chk("gcnt1", g1, sat(c1, 255));
    chk("gcnt0_w2", s0, sat(c0, 3));
    chk("gcnt1_w2", s1, sat(c1, 3));
    if (v0 && v1) g = prio_m;
    else if (v0) g = 0;
    else if (v1) g = 1;
    else g = -1;
    room = !busy_m || ordy;
    a0 = (g == 0) && room;
    a1 = (g == 1) && room;
    chk("req0_ready", bus.Req0Ready, a0);
    chk("req1_ready", bus.Req1Ready, a1);
    if (a0 || a1) begin
      q.push_back('{ext_m(a1 ? d1 : d0, a1 ? m1 : m0), a1});
      prio_m = 1 - g;
      busy_m = 1;
      if (a0) c0++;
      else c1++;
    end else if (ordy) begin
      busy_m = 0;
    end
  endtask

  task automatic peek_out(string name, logic [31:0] d, logic id);
    @(posedge Clk);
    #1;
    chk({name, "_valid"}, bus.OutValid, 1'b1);
    chk({name, "_data"}, bus.OutData, d);
    chk({name, "_id"}, bus.OutId, id);
  endtask

  task automatic async_reset();
    Reset = 1'b1;
    #1;
    chk("rst_valid", bus.OutValid, 1'b0);
    chk("rst_data", bus.OutData, 32'h0);
    chk("rst_cnt0", g0, 8'h00);
    model_reset();
    #1;
    Reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (!Reset && bus.OutValid && bus.OutReady) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL pop: got %h with empty queue, want no output",
                   bus.OutData);
        end else begin
          e = q.pop_front();
          chk("sb_data", bus.OutData, e.data);
          chk("sb_id", bus.OutId, e.id);
        end
      end
    end
  end

  initial begin : stim
    bit          a0, a1;
    bit          v0, v1, ordy;
    logic [15:0] d0, d1;
    logic [1:0]  m0, m1;
    logic [31:0] held;

    Reset = 1'b1;
    bus.Req0Valid = 0; bus.Req0Data = 0; bus.Req0Mode = 0;
    bus.Req1Valid = 0; bus.Req1Data = 0; bus.Req1Mode = 0;
    bus.OutReady  = 0;
    model_reset();
    #3;
    chk("init_valid", bus.OutValid, 1'b0);
    chk("init_data", bus.OutData, 32'h0);
    chk("init_id", bus.OutId, 1'b0);
    @(posedge Clk);
    #2;
    Reset = 1'b0;

    cycle(1, 16'h8001, 2'd0, 0, 16'h0, 2'd0, 1, a0, a1);
    peek_out("first", 32'hFFFF8001, 1'b0);
    chk("first_cnt0", g0, 8'd1);

    cycle(0, 16'h0, 2'd0, 1, 16'h80F0, 2'd1, 1, a0, a1);
    peek_out("mode01", 32'h000080F0, 1'b1);
    cycle(0, 16'h0, 2'd0, 1, 16'h80F0, 2'd2, 1, a0, a1);
    peek_out("mode10", 32'hFFFFFFF0, 1'b1);
    cycle(0, 16'h0, 2'd0, 1, 16'h80F0, 2'd3, 1, a0, a1);
    peek_out("mode11", 32'h80F00000, 1'b1);
    cycle(0, 16'h0, 2'd0, 1, 16'h7FFF, 2'd0, 1, a0, a1);
    peek_out("mode00", 32'h00007FFF, 1'b1);
    async_reset();

    for (int i = 0; i < 6; i++) begin
      cycle(1, 16'h1234, 2'd1, 1, 16'hF00D, 2'd1, 1, a0, a1);
      peek_out("alt", (i % 2) ? 32'h0000F00D : 32'h00001234, 1'(i % 2));
    end
    chk("alt_cnt0", g0, 8'd3);
    chk("alt_cnt1", g1, 8'd3);

    cycle(1, 16'h00AA, 2'd1, 1, 16'h00BB, 2'd1, 1, a0, a1);
    peek_out("stall_pre", 32'h000000AA, 1'b0);
    held = bus.OutData;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 16'h00AA, 2'd1, 1, 16'h00BB, 2'd1, 0, a0, a1);
      peek_out("stall_hold", held, 1'b0);
    end
    cycle(1, 16'h00AA, 2'd1, 1, 16'h00BB, 2'd1, 1, a0, a1);
    peek_out("stall_rel", 32'h000000BB, 1'b1);

    async_reset();
    cycle(1, 16'h0001, 2'd1, 1, 16'h0002, 2'd1, 1, a0, a1);
    peek_out("post_rst", 32'h00000001, 1'b0);

    async_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 16'(i), 2'd1, 0, 16'h0, 2'd0, 1, a0, a1);
    end
    @(posedge Clk);
    #1;
    chk("sat_w2", s0, 2'd3);
    chk("sat_w8", g0, 8'd5);
    cycle(1, 16'h5, 2'd1, 0, 16'h0, 2'd0, 1, a0, a1);
    @(posedge Clk);
    #1;
    chk("sat_w2_hold", s0, 2'd3);

    v0 = 0; v1 = 0; a0 = 0; a1 = 0;
    d0 = 0; d1 = 0; m0 = 0; m1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(v0 && !a0)) begin
        v0 = 1'($urandom_range(0, 1));
        d0 = 16'($urandom);
        m0 = 2'($urandom);
      end
      if (!(v1 && !a1)) begin
        v1 = 1'($urandom_range(0, 1));
        d1 = 16'($urandom);
        m1 = 2'($urandom);
      end
      ordy = ($urandom_range(0, 3) != 0);
      cycle(v0, d0, m0, v1, d1, m1, ordy, a0, a1);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 16'h0, 2'd0, 0, 16'h0, 2'd0, 1, a0, a1);
    end
    @(negedge Clk);
    #3;
    chk("queue_empty", q.size(), 0);
    chk("drained_valid", bus.OutValid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
